// File: rtl/vga_display_sequencer.sv
// vga_display_sequencer
//
// Raster timing and snapshot sequencing for the debug text display.
// It generates 640x480@60 counters, sync and blanking from the 25 MHz pixel
// clock. It derives 8x16 character-cell coordinates. Once per frame it runs a
// request/acknowledge exchange with the processor-state capture stage. This
// keeps the values shown on screen fixed while the active region is drawn.
//
// Ports
//   clk          pixel clock (only clock)
//   reset        synchronous, active-high
//   freeze       suppresses the per-frame snapshot request while high
//   snap_ack     capture stage has latched processor state
//   x, y         raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   video_on     inside the visible region
//   hsync/vsync  sync pulses, level SYNC_ACTIVE while asserted
//   char_col/char_row, glyph_x/glyph_y   character cell and pixel-in-glyph
//   frame_start  one-cycle pulse at (0,0)
//   snap_req     snapshot request
//   snap_valid   sticky: a snapshot has completed since reset
//   snap_miss    one-cycle pulse when a request times out at end of frame
//   frame_count  completed frames, wrapping
module vga_display_sequencer #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic        snap_ack,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic [6:0]  char_col,
  output logic [4:0]  char_row,
  output logic [2:0]  glyph_x,
  output logic [3:0]  glyph_y,
  output logic        frame_start,
  output logic        snap_req,
  output logic        snap_valid,
  output logic        snap_miss,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_e;

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [15:0] fc_q, fc_d;
  state_e      st_q, st_d;
  logic        valid_q, valid_d;
  logic        req_c, miss_c;

  logic line_end, frame_end, at_origin, at_req_pt;
  logic hs_win, vs_win;

  assign line_end  = (x_q == X_LAST);
  assign frame_end = line_end && (y_q == Y_LAST);
  assign at_origin = (x_q == 10'd0) && (y_q == 10'd0);
  assign at_req_pt = (x_q == 10'd0) && (y_q == Y_ACT);
  assign hs_win    = (x_q >= HS_BEG) && (x_q < HS_END);
  assign vs_win    = (y_q >= VS_BEG) && (y_q < VS_END);

  // Raster counters
  always_comb begin
    x_d  = x_q + 10'd1;
    y_d  = y_q;
    fc_d = fc_q;
    if (line_end) begin
      x_d = 10'd0;
      if (y_q == Y_LAST) begin
        y_d  = 10'd0;
        fc_d = fc_q + 16'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
  end

  // Snapshot sequencing. The request is raised combinationally on the first
  // blanking line (x=0, y=V_ACTIVE), so snap_req is already high in that
  // cycle. The state register then holds it until ack or end of frame. An ack
  // on the final cycle of the frame beats the timeout.
  always_comb begin
    st_d    = st_q;
    valid_d = valid_q;
    req_c   = 1'b0;
    miss_c  = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (at_req_pt && !freeze) begin
          req_c = 1'b1;
          if (snap_ack) begin
            st_d    = S_HOLD;
            valid_d = 1'b1;
          end else begin
            st_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        req_c = 1'b1;
        if (snap_ack) begin
          st_d    = S_HOLD;
          valid_d = 1'b1;
        end else if (frame_end) begin
          st_d   = S_IDLE;
          miss_c = 1'b1;
        end
      end
      S_HOLD: begin
        if (at_origin) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      fc_q    <= 16'd0;
      st_q    <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      st_q    <= st_d;
      valid_q <= valid_d;
    end
  end

  // Output decode: zero latency from x/y, and forced to idle levels while
  // reset is high so a mid-frame reset is clean in its very first cycle.
  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = fc_q;
  assign snap_valid  = valid_q;
  assign char_col    = x_q[9:3];
  assign char_row    = y_q[8:4];
  assign glyph_x     = x_q[2:0];
  assign glyph_y     = y_q[3:0];
  assign video_on    = !reset && (x_q < X_ACT) && (y_q < Y_ACT);
  assign hsync       = (hs_win && !reset) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync       = (vs_win && !reset) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign frame_start = !reset && at_origin;
  assign snap_req    = req_c && !reset;
  assign snap_miss   = miss_c && !reset;

endmodule

// File: tb/tb_vga_display_sequencer.sv
// Bench for vga_display_sequencer. The main instance uses shrunken timing so
// that whole frames are cheap to simulate. A second instance with the default
// 640x480 timing checks the real horizontal numbers over the first lines.
module tb_vga_display_sequencer;

  localparam int HA = 64, HF = 6, HS = 10, HB = 4;
  localparam int VA = 32, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1, freeze = 1'b0, snap_ack = 1'b0;
  always #20 clk = ~clk;

  logic [9:0]  x, y;
  logic        video_on, hsync, vsync, frame_start, snap_req, snap_valid, snap_miss;
  logic [6:0]  char_col;
  logic [4:0]  char_row;
  logic [2:0]  glyph_x;
  logic [3:0]  glyph_y;
  logic [15:0] frame_count;

  logic [9:0]  d_x, d_y;
  logic        d_video_on, d_hsync, d_vsync, d_frame_start, d_snap_req, d_snap_valid, d_snap_miss;
  logic [6:0]  d_char_col;
  logic [4:0]  d_char_row;
  logic [2:0]  d_glyph_x;
  logic [3:0]  d_glyph_y;
  logic [15:0] d_frame_count;

  vga_display_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .snap_ack(snap_ack),
    .x(x), .y(y), .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .char_col(char_col), .char_row(char_row), .glyph_x(glyph_x), .glyph_y(glyph_y),
    .frame_start(frame_start), .snap_req(snap_req), .snap_valid(snap_valid),
    .snap_miss(snap_miss), .frame_count(frame_count)
  );

  vga_display_sequencer dut_def (
    .clk(clk), .reset(reset), .freeze(freeze), .snap_ack(snap_ack),
    .x(d_x), .y(d_y), .video_on(d_video_on), .hsync(d_hsync), .vsync(d_vsync),
    .char_col(d_char_col), .char_row(d_char_row), .glyph_x(d_glyph_x), .glyph_y(d_glyph_y),
    .frame_start(d_frame_start), .snap_req(d_snap_req), .snap_valid(d_snap_valid),
    .snap_miss(d_snap_miss), .frame_count(d_frame_count)
  );

  int errors = 0, checks = 0;
  int cyc_cnt = 0, last_fs = 0;

  // Reference model: position is a plain cycle count since reset release;
  // the snapshot exchange is tracked as "request open" plus "valid seen".
  int   n = 0;
  bit   m_open = 1'b0, m_valid = 1'b0;
  int   ex, ey, e_fc;
  logic e_video, e_hs, e_vs, e_fs, e_req, e_miss;

  task automatic model_eval();
    ex      = n % HT;
    ey      = (n / HT) % VT;
    e_fc    = (n / FRAME) % 65536;
    e_video = !reset && ex < HA && ey < VA;
    e_hs    = reset || !(ex >= HA + HF && ex < HA + HF + HS);
    e_vs    = reset || !(ey >= VA + VF && ey < VA + VF + VS);
    e_fs    = !reset && ex == 0 && ey == 0;
    e_req   = !reset && (m_open || (ex == 0 && ey == VA && !freeze));
    e_miss  = e_req && !snap_ack && ex == HT - 1 && ey == VT - 1;
  endtask

  function automatic bit at_pos(int tx, int ty);
    return (n % HT == tx) && ((n / HT) % VT == ty);
  endfunction

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic step();
    model_eval();
    if (reset) begin
      n = 0; m_open = 1'b0; m_valid = 1'b0;
    end else begin
      if (e_req && snap_ack) begin
        m_open = 1'b0; m_valid = 1'b1;
      end else if (e_req && ex == HT - 1 && ey == VT - 1) begin
        m_open = 1'b0;
      end else begin
        m_open = e_req;
      end
      n++;
    end
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic goto(int tx, int ty);
    freeze = 1'b1; snap_ack = 1'b0;
    for (int i = 0; i < FRAME + 2 && !at_pos(tx, ty); i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; freeze = 1'b0; snap_ack = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++; if ({x, y} !== 20'd0) begin errors++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x, y); end
      checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc: got %0d expected 0", frame_count); end
      checks++; if ({snap_req, snap_valid, snap_miss, frame_start, video_on} !== 5'b0) begin
        errors++; $display("FAIL reset_ctl: got %b expected 00000", {snap_req, snap_valid, snap_miss, frame_start, video_on}); end
      checks++; if ({hsync, vsync} !== 2'b11) begin errors++; $display("FAIL reset_sync: got %b expected 11", {hsync, vsync}); end
      checks++; if ({d_x, d_y, d_video_on, d_hsync, d_vsync, d_snap_req, d_snap_valid} !== {20'd0, 5'b01100}) begin
        errors++; $display("FAIL reset_def: got x=%0d y=%0d v/h/vs/r/val=%b", d_x, d_y, {d_video_on, d_hsync, d_vsync, d_snap_req, d_snap_valid}); end
      step();
    end
    reset = 1'b0;
    sample();
    checks++; if ({x, y} !== 20'd0) begin errors++; $display("FAIL release_xy: got x=%0d y=%0d expected 0 0", x, y); end
    checks++; if ({frame_start, video_on, hsync, vsync} !== 4'b1111) begin
      errors++; $display("FAIL release_dec: got fs/vid/hs/vs=%b expected 1111", {frame_start, video_on, hsync, vsync}); end
    checks++; if ({d_frame_start, d_video_on, d_hsync, d_vsync} !== 4'b1111) begin
      errors++; $display("FAIL release_def: got fs/vid/hs/vs=%b expected 1111", {d_frame_start, d_video_on, d_hsync, d_vsync}); end
    last_fs = cyc_cnt;
    step();
  endtask

  task automatic test_raster();
    int seen = 0;
    freeze = 1'b1; snap_ack = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      sample();
      checks++; if (x !== 10'(ex) || y !== 10'(ey)) begin errors++; $display("FAIL raster_xy: got %0d,%0d expected %0d,%0d", x, y, ex, ey); end
      checks++; if ({video_on, hsync, vsync, frame_start} !== {e_video, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL raster_dec at %0d,%0d: got %b expected %b", ex, ey, {video_on, hsync, vsync, frame_start}, {e_video, e_hs, e_vs, e_fs}); end
      checks++; if (char_col !== 7'(ex / 8) || char_row !== 5'(ey / 16) || glyph_x !== 3'(ex % 8) || glyph_y !== 4'(ey % 16)) begin
        errors++; $display("FAIL raster_cell at %0d,%0d: got %0d %0d %0d %0d", ex, ey, char_col, char_row, glyph_x, glyph_y); end
      checks++; if (frame_count !== 16'(e_fc)) begin errors++; $display("FAIL raster_fc: got %0d expected %0d", frame_count, e_fc); end
      if (frame_start === 1'b1) begin
        seen++;
        checks++; if (cyc_cnt - last_fs !== FRAME) begin errors++; $display("FAIL frame_period: got %0d expected %0d", cyc_cnt - last_fs, FRAME); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL second_frame_fc: got %0d expected 1", frame_count); end
        last_fs = cyc_cnt;
      end
      step();
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", seen); end
  endtask

  task automatic test_default_timing();
    int dx, dy;
    reset = 1'b1; freeze = 1'b1; snap_ack = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2 * 800 + 40; i++) begin
      sample();
      dx = i % 800; dy = i / 800;
      checks++; if (d_x !== 10'(dx) || d_y !== 10'(dy)) begin errors++; $display("FAIL def_xy: got %0d,%0d expected %0d,%0d", d_x, d_y, dx, dy); end
      checks++; if (d_hsync !== !(dx >= 656 && dx < 752) || d_video_on !== (dx < 640) || d_vsync !== 1'b1 || d_frame_start !== (i == 0)) begin
        errors++; $display("FAIL def_dec at x=%0d: got hs=%b vid=%b vs=%b fs=%b", dx, d_hsync, d_video_on, d_vsync, d_frame_start); end
      step();
    end
  endtask

  task automatic test_ack_after_3();
    goto(0, VA);
    freeze = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      snap_ack = (k == 3);
      sample();
      checks++; if ({snap_req, snap_valid, snap_miss} !== {e_req, m_valid, e_miss}) begin
        errors++; $display("FAIL ack3_model k=%0d: got %b expected %b", k, {snap_req, snap_valid, snap_miss}, {e_req, m_valid, e_miss}); end
      checks++; if (snap_req !== (k <= 3)) begin errors++; $display("FAIL ack3_req k=%0d: got %b expected %b", k, snap_req, k <= 3); end
      if (k == 4) begin
        checks++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL ack3_valid: got %b expected 1", snap_valid); end
      end
      step();
    end
    snap_ack = 1'b0;
    sample();
    checks++; if (snap_req !== 1'b1 || x !== 10'd0 || y !== 10'(VA)) begin
      errors++; $display("FAIL ack3_next_req: got req=%b at %0d,%0d expected 1 at 0,%0d", snap_req, x, y, VA); end
    step();
  endtask

  task automatic test_timeout();
    int len = (VT - VA) * HT;
    goto(0, VA);
    freeze = 1'b0;
    for (int k = 0; k < len; k++) begin
      sample();
      checks++; if (snap_req !== 1'b1 || snap_miss !== (k == len - 1)) begin
        errors++; $display("FAIL timeout_k%0d: got req=%b miss=%b expected 1 %b", k, snap_req, snap_miss, k == len - 1); end
      if (k == len - 1) begin
        checks++; if (x !== 10'(HT - 1) || y !== 10'(VT - 1)) begin errors++; $display("FAIL timeout_pos: got %0d,%0d expected %0d,%0d", x, y, HT - 1, VT - 1); end
      end
      step();
    end
    sample();
    checks++; if ({snap_req, snap_miss} !== 2'b00) begin errors++; $display("FAIL timeout_after: got %b expected 00", {snap_req, snap_miss}); end
    step();
    goto(0, VA);
    freeze = 1'b0;
    for (int k = 0; k < len; k++) begin
      snap_ack = (k == len - 1);
      sample();
      checks++; if (snap_req !== 1'b1 || snap_miss !== 1'b0) begin
        errors++; $display("FAIL lastack_k%0d: got req=%b miss=%b expected 1 0", k, snap_req, snap_miss); end
      step();
    end
    snap_ack = 1'b0;
    sample();
    checks++; if ({snap_req, snap_miss, snap_valid} !== 3'b001) begin
      errors++; $display("FAIL lastack_hold: got req/miss/valid=%b expected 001", {snap_req, snap_miss, snap_valid}); end
    step();
  endtask

  task automatic test_freeze();
    logic v0;
    goto(0, VA);
    v0 = snap_valid;
    for (int k = 0; k < (VT - VA) * HT + 10; k++) begin
      sample();
      checks++; if (snap_req !== 1'b0 || snap_valid !== v0) begin
        errors++; $display("FAIL freeze_hold k=%0d: got req=%b valid=%b expected 0 %b", k, snap_req, snap_valid, v0); end
      step();
    end
    goto(0, VA);
    freeze = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) freeze = 1'b1;
      snap_ack = (k == 30);
      sample();
      checks++; if (snap_req !== (k <= 30)) begin errors++; $display("FAIL freeze_in_req k=%0d: got %b expected %b", k, snap_req, k <= 30); end
      step();
    end
    freeze = 1'b0; snap_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    goto(0, VA);
    freeze = 1'b0;
    for (int i = 0; i < FRAME && !at_pos(HT / 2, VA + 5); i++) begin
      sample();
      checks++; if (snap_req !== 1'b1) begin errors++; $display("FAIL mid_pre_req: got %b expected 1", snap_req); end
      step();
    end
    reset = 1'b1;
    sample();
    checks++; if ({video_on, hsync, vsync, frame_start, snap_req, snap_miss} !== 6'b011000) begin
      errors++; $display("FAIL mid_reset_dec: got %b expected 011000", {video_on, hsync, vsync, frame_start, snap_req, snap_miss}); end
    step();
    sample();
    checks++; if ({x, y} !== 20'd0 || snap_req !== 1'b0 || snap_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_next: got x=%0d y=%0d req=%b valid=%b expected 0 0 0 0", x, y, snap_req, snap_valid); end
    step();
    reset = 1'b0;
    sample();
    checks++; if ({x, y} !== 20'd0 || frame_start !== 1'b1 || snap_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release: got x=%0d y=%0d fs=%b valid=%b expected 0 0 1 0", x, y, frame_start, snap_valid); end
    step();
    goto(0, VA);
    freeze = 1'b0;
    for (int k = 0; k < 6; k++) begin
      snap_ack = (k == 2);
      sample();
      checks++; if (snap_req !== (k <= 2)) begin errors++; $display("FAIL mid_resume_req k=%0d: got %b expected %b", k, snap_req, k <= 2); end
      step();
    end
    snap_ack = 1'b0;
    sample();
    checks++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL mid_resume_valid: got %b expected 1", snap_valid); end
    step();
  endtask

  task automatic test_random();
    int mode;
    for (int f = 0; f < 4; f++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < FRAME; i++) begin
        freeze = ($urandom_range(0, 7) == 0);
        case (mode)
          0:       snap_ack = 1'b0;
          1:       snap_ack = ($urandom_range(0, 15) == 0);
          default: snap_ack = ($urandom_range(0, 299) == 0);
        endcase
        if (at_pos(0, VA)) snap_ack = 1'b0;
        sample();
        checks++; if (x !== 10'(ex) || y !== 10'(ey) || frame_count !== 16'(e_fc)) begin
          errors++; $display("FAIL rand_pos: got %0d,%0d fc=%0d expected %0d,%0d fc=%0d", x, y, frame_count, ex, ey, e_fc); end
        checks++; if ({video_on, hsync, vsync, frame_start, snap_req, snap_miss, snap_valid} !== {e_video, e_hs, e_vs, e_fs, e_req, e_miss, m_valid}) begin
          errors++; $display("FAIL rand_out at %0d,%0d: got %b expected %b", ex, ey,
            {video_on, hsync, vsync, frame_start, snap_req, snap_miss, snap_valid}, {e_video, e_hs, e_vs, e_fs, e_req, e_miss, m_valid}); end
        checks++; if (snap_req === 1'b1 && video_on === 1'b1) begin errors++; $display("FAIL rand_req_visible: got req=1 vid=1 expected not both"); end
        step();
      end
    end
    freeze = 1'b0; snap_ack = 1'b0;
  endtask

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raster();
    test_default_timing();
    test_ack_after_3();
    test_timeout();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
